// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between execute stage and muldiv_unit
//
// master : execute stage (drives start, flush, funct3, rs1_data, rs2_data, rd_in)
// slave  : muldiv_unit   (drives busy, done, result, rd_out, wb_en)

interface muldiv_unit_if;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wb_en;

    modport master (
        output start, flush, funct3, rs1_data, rs2_data, rd_in,
        input  busy, done, result, rd_out, wb_en
    );

    modport slave (
        input  start, flush, funct3, rs1_data, rs2_data, rd_in,
        output busy, done, result, rd_out, wb_en
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - muldiv_unit_if.slave
//            start/flush/funct3/rs1_data/rs2_data/rd_in in,
//            busy/done/result/rd_out/wb_en out (drive the register file write port)
//
// Build option: MULDIV_FAST_MUL_EN - multiplies complete through a single-cycle
// multiplier straight from IDLE to DONE; divides keep the iterative path.
// Without it every op takes 32 shift/subtract iterations and no multiplier is built.

module muldiv_unit (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  op_q;
    logic        neg_q;     // final result must be negated
    logic        div0_q;
    logic [31:0] a_q;       // multiplier (shifts right) or dividend -> quotient (shifts left)
    logic [63:0] m_q;       // multiplicand (shifts left) or divisor in [31:0]
    logic [63:0] acc_q;     // product, or partial remainder in [32:0]
    logic [5:0]  cnt_q;
    logic [31:0] result_q;
    logic [4:0]  rd_q;

    // operand decode at acceptance
    logic        sgn1;
    logic        sgn2;
    logic        s1;
    logic        s2;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic        accept;
    logic        fast_op;

    always_comb begin
        sgn1 = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
               (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
        sgn2 = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
        s1   = sgn1 & bus.rs1_data[31];
        s2   = sgn2 & bus.rs2_data[31];
        abs1 = s1 ? (~bus.rs1_data + 32'd1) : bus.rs1_data;
        abs2 = s2 ? (~bus.rs2_data + 32'd1) : bus.rs2_data;
    end

    assign accept = (state == IDLE) && bus.start && !bus.flush;

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extended operands; the 64-bit wrapped product is exact, so this is
    // effectively a 33x33 signed multiply.
    logic signed [63:0] fast_a;
    logic signed [63:0] fast_b;
    logic signed [63:0] fast_p;
    logic [31:0]        fast_res;

    always_comb begin
        fast_a   = {{32{s1}}, bus.rs1_data};
        fast_b   = {{32{s2}}, bus.rs2_data};
        fast_p   = fast_a * fast_b;
        fast_res = (bus.funct3 == 3'd0) ? fast_p[31:0] : fast_p[63:32];
        fast_op  = !bus.funct3[2];
    end
`else
    assign fast_op = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start) state_nxt = fast_op ? DONE : CALC;
                CALC: if (cnt_q == 6'd31) state_nxt = FIX;
                FIX:  state_nxt = DONE;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // restoring-divide step: shift next dividend bit into the partial remainder
    logic [32:0] rem_sh;
    logic [32:0] diff;

    always_comb begin
        rem_sh = {acc_q[31:0], a_q[31]};
        diff   = rem_sh - {1'b0, m_q[31:0]};
    end

    // sign correction and word select
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] fix_res;

    always_comb begin
        prod = neg_q ? (~acc_q + 64'd1) : acc_q;
        // magnitude path would yield all ones anyway; forcing it keeps the sign fix out
        quo  = div0_q ? 32'hFFFF_FFFF : (neg_q ? (~a_q + 32'd1) : a_q);
        rem  = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        case (op_q)
            3'd0:              fix_res = prod[31:0];
            3'd1, 3'd2, 3'd3:  fix_res = prod[63:32];
            3'd4, 3'd5:        fix_res = quo;
            default:           fix_res = rem;
        endcase
    end

    // datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            a_q      <= 32'd0;
            m_q      <= 64'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 6'd0;
            result_q <= 32'd0;
            rd_q     <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= bus.funct3;
                        // remainder follows the dividend; everything else the sign product
                        neg_q  <= (bus.funct3 == 3'd6) ? s1 : (s1 ^ s2);
                        div0_q <= (bus.rs2_data == 32'd0);
                        a_q    <= abs1;
                        m_q    <= {32'd0, abs2};
                        acc_q  <= 64'd0;
                        cnt_q  <= 6'd0;
                        rd_q   <= bus.rd_in;
`ifdef MULDIV_FAST_MUL_EN
                        if (fast_op) result_q <= fast_res;
`endif
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        cnt_q <= cnt_q + 6'd1;
                        if (!op_q[2]) begin
                            if (a_q[0]) acc_q <= acc_q + m_q;
                            m_q <= m_q << 1;
                            a_q <= a_q >> 1;
                        end else if (!diff[32]) begin
                            acc_q <= {31'd0, diff};
                            a_q   <= {a_q[30:0], 1'b1};
                        end else begin
                            acc_q <= {31'd0, rem_sh};
                            a_q   <= {a_q[30:0], 1'b0};
                        end
                    end
                end
                FIX: begin
                    if (!bus.flush) result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

    // outputs: decoded from registered state only
    always_comb begin
        bus.busy   = (state != IDLE);
        bus.done   = (state == DONE);
        bus.wb_en  = (state == DONE) && (rd_q != 5'd0);
        bus.result = result_q;
        bus.rd_out = rd_q;
    end

endmodule
